// File: rtl/div_ratio_ctrl.sv
// Run-time divide-ratio controller: glitch-free ratio changes at period boundaries, clean start/stop.
// Optional DIV_RATIO_CTRL_DUTY50_EN adds a negedge flop so odd ratios get a 50% duty clk_out.
module div_ratio_ctrl #(
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] pend_div, pend_div_nxt;
    logic             pend, pend_nxt;
    logic             clk_out_r, clk_out_nxt;
    logic             done_nxt, err_nxt;
    logic             running, wrap, xfer, legal;

    assign running   = (state != IDLE);
    assign wrap      = running && (cnt == cur_div - DIV_W'(1));
    assign cfg_ready = !pend;
    assign xfer      = cfg_valid && cfg_ready;
    assign legal     = (cfg_div >= DIV_W'(2));
    assign busy      = running;
    assign tick      = wrap;

    always_comb begin
        state_nxt    = state;
        div_nxt      = cur_div;
        pend_nxt     = pend;
        pend_div_nxt = pend_div;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;

        unique case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = STOP;
            STOP: begin
                if (en)        state_nxt = RUN;
                else if (wrap) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // A ratio only takes effect where cnt restarts at 0, so a period is never cut short.
        if (xfer && !legal) begin
            err_nxt = 1'b1;
        end else if (xfer && (!running || wrap)) begin
            div_nxt  = cfg_div;
            done_nxt = 1'b1;
        end else if (xfer) begin
            pend_nxt     = 1'b1;
            pend_div_nxt = cfg_div;
        end else if (wrap && pend) begin
            div_nxt  = pend_div;
            pend_nxt = 1'b0;
            done_nxt = 1'b1;
        end

        cnt_nxt     = (running && !wrap) ? cnt + DIV_W'(1) : '0;
        clk_out_nxt = (state_nxt != IDLE) && (cnt_nxt < (div_nxt >> 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_div   <= DIV_W'(DIV_INIT);
            pend      <= 1'b0;
            pend_div  <= '0;
            clk_out_r <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur_div   <= div_nxt;
            pend      <= pend_nxt;
            pend_div  <= pend_div_nxt;
            clk_out_r <= clk_out_nxt;
            cfg_done  <= done_nxt;
            cfg_err   <= err_nxt;
        end
    end

`ifdef DIV_RATIO_CTRL_DUTY50_EN
    // Half-cycle delayed copy stretches the high phase by half a clk for odd ratios.
    logic clk_out_n;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) clk_out_n <= 1'b0;
        else     clk_out_n <= clk_out_r;
    end

    assign clk_out = cur_div[0] ? (clk_out_r | clk_out_n) : clk_out_r;
`else
    assign clk_out = clk_out_r;
`endif

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Scoreboard bench for div_ratio_ctrl: expected per-cycle outputs are queued as stimulus is driven.
module tb_div_ratio_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready, cfg_done, cfg_err, clk_out, tick, busy;
    logic [7:0] cur_div;

    div_ratio_ctrl #(.DIV_W(8), .DIV_INIT(10)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .clk_out(clk_out), .tick(tick), .busy(busy), .cur_div(cur_div)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       clk_out;
        logic       tick;
        logic       busy;
        logic       ready;
        logic       done;
        logic       err;
        logic [7:0] div;
    } obs_t;

    obs_t exp_q[$];
    logic lvl_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t mk(logic c, logic t, logic b, logic r, logic d, logic e, logic [7:0] v);
        obs_t o;
        o = '{clk_out: c, tick: t, busy: b, ready: r, done: d, err: e, div: v};
        return o;
    endfunction

    function automatic obs_t snap();
        obs_t o;
        o = '{clk_out: clk_out, tick: tick, busy: busy, ready: cfg_ready,
              done: cfg_done, err: cfg_err, div: cur_div};
        return o;
    endfunction

    task automatic test_reset();
        obs_t e, a;
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        repeat (3) @(negedge clk);
        e = mk(0, 0, 0, 1, 0, 0, 8'd10); a = snap();
        n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL reset_state got %h want %h", a, e); end
        rst = 1'b0;
        @(negedge clk);
        a = snap();
        n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL idle_after_reset got %h want %h", a, e); end
    endtask

    task automatic test_run_n10();
        obs_t e, a;
        int   ticks = 0;
        en = 1'b1;
        for (int k = 0; k < 20; k++) exp_q.push_back(mk((k % 10) < 5, (k % 10) == 9, 1, 1, 0, 0, 8'd10));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            e = exp_q.pop_front(); a = snap();
            if (tick) ticks++;
            n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL run_n10[%0d] got %h want %h", k, a, e); end
        end
        n_cmp++;
        if (ticks != 2) begin n_bad++; $display("FAIL run_n10_ticks got %0d want 2", ticks); end
    endtask

    task automatic test_ratio_change();
        obs_t e, a;
        int   dones = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 8'd10));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp_q.pop_front(); a = snap();
            n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL pre_change[%0d] got %h want %h", k, a, e); end
        end
        cfg_valid = 1'b1; cfg_div = 8'd4;
        for (int c = 4; c < 10; c++) exp_q.push_back(mk(c < 5, c == 9, 1, 0, 0, 0, 8'd10));
        for (int j = 0; j < 12; j++) exp_q.push_back(mk((j % 4) < 2, (j % 4) == 3, 1, 1, j == 0, 0, 8'd4));
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            e = exp_q.pop_front(); a = snap();
            if (cfg_done) dones++;
            n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL ratio_change[%0d] got %h want %h", k, a, e); end
            if (k == 0) cfg_valid = 1'b0;
        end
        n_cmp++;
        if (dones != 1) begin n_bad++; $display("FAIL ratio_change_done_count got %0d want 1", dones); end
    endtask

    task automatic test_illegal();
        obs_t e, a;
        cfg_valid = 1'b1; cfg_div = 8'd1;
        for (int j = 0; j < 8; j++)
            exp_q.push_back(mk((j % 4) < 2, (j % 4) == 3, 1, 1, 0, (j == 0) || (j == 2), 8'd4));
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            e = exp_q.pop_front(); a = snap();
            n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL illegal[%0d] got %h want %h", j, a, e); end
            if (j == 0) cfg_valid = 1'b0;
            if (j == 1) begin cfg_valid = 1'b1; cfg_div = 8'd0; end
            if (j == 2) cfg_valid = 1'b0;
        end
    endtask

    task automatic test_stop();
        obs_t e, a;
        int   ticks = 0;
        // offered in the last cycle of an N=4 period: takes effect on that same wrap edge
        cfg_valid = 1'b1; cfg_div = 8'd6;
        exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 8'd6));
        exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 8'd6));
        exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 8'd6));
        exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 8'd6));
        exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 8'd6));
        exp_q.push_back(mk(0, 1, 1, 1, 0, 0, 8'd6));
        for (int j = 0; j < 4; j++) exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 8'd6));
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            e = exp_q.pop_front(); a = snap();
            if (j >= 3 && tick) ticks++;
            n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL stop[%0d] got %h want %h", j, a, e); end
            if (j == 0) cfg_valid = 1'b0;
            if (j == 2) en = 1'b0;
        end
        n_cmp++;
        if (ticks != 1) begin n_bad++; $display("FAIL stop_ticks got %0d want 1", ticks); end
    endtask

    task automatic test_duty();
        obs_t e, a;
        logic exp_l, got;
        int   w = 0;
        cfg_valid = 1'b1; cfg_div = 8'd3;
        @(negedge clk);
        e = mk(0, 0, 0, 1, 1, 0, 8'd3); a = snap();
        n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL idle_cfg3 got %h want %h", a, e); end
        cfg_valid = 1'b0; en = 1'b1;
        for (int k = 0; k < 6; k++) begin
`ifdef DIV_RATIO_CTRL_DUTY50_EN
            lvl_q.push_back((k % 3) <= 1);
`else
            lvl_q.push_back((k % 3) == 0);
`endif
            lvl_q.push_back((k % 3) == 0);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #2;
            exp_l = lvl_q.pop_front(); got = clk_out;
            n_cmp++;
            if (got !== exp_l) begin n_bad++; $display("FAIL n3_rise[%0d] got %b want %b", k, got, exp_l); end
            @(negedge clk); #2;
            exp_l = lvl_q.pop_front(); got = clk_out;
            n_cmp++;
            if (got !== exp_l) begin n_bad++; $display("FAIL n3_fall[%0d] got %b want %b", k, got, exp_l); end
        end
        cfg_valid = 1'b1; cfg_div = 8'd2;
        for (int k = 0; k < 4; k++) begin
            lvl_q.push_back((k % 2) == 0);
            lvl_q.push_back((k % 2) == 0);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            cfg_valid = 1'b0;
            exp_l = lvl_q.pop_front(); got = clk_out;
            n_cmp++;
            if (got !== exp_l) begin n_bad++; $display("FAIL n2_rise[%0d] got %b want %b", k, got, exp_l); end
            @(negedge clk); #2;
            exp_l = lvl_q.pop_front(); got = clk_out;
            n_cmp++;
            if (got !== exp_l) begin n_bad++; $display("FAIL n2_fall[%0d] got %b want %b", k, got, exp_l); end
        end
        n_cmp++;
        if (cur_div !== 8'd2) begin n_bad++; $display("FAIL n2_div got %0d want 2", cur_div); end
        en = 1'b0;
        while (busy && w < 20) begin @(negedge clk); w++; end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL duty_stop_timeout busy=%b want 0", busy); end
    endtask

    task automatic test_async_reset();
        obs_t e, a;
        int   dones = 0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_div = 8'd12;
        @(negedge clk);
        e = mk(0, 0, 0, 1, 1, 0, 8'd12); a = snap();
        n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL idle_cfg12 got %h want %h", a, e); end
        cfg_valid = 1'b0; en = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 8'd12));
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 8'd12));
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 8'd12));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            e = exp_q.pop_front(); a = snap();
            n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL pre_rst[%0d] got %h want %h", k, a, e); end
            if (k == 2) begin cfg_valid = 1'b1; cfg_div = 8'd5; end
            if (k == 3) cfg_valid = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        e = mk(0, 0, 0, 1, 0, 0, 8'd10); a = snap();
        n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL async_rst got %h want %h", a, e); end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (cfg_done) dones++;
        end
        a = snap();
        n_cmp++;
        if (a !== e || dones != 0) begin
            n_bad++;
            $display("FAIL post_rst got %h dones=%0d want %h dones=0", a, dones, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_run_n10();
        test_ratio_change();
        test_illegal();
        test_stop();
        test_duty();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
